// File: rtl/myreg_requester.sv
// rtl/myreg_requester.sv - single-register accelerator initiator bridging RoCC command/response handshakes
module myreg_requester #(
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 5,
    parameter int TIMEOUT    = 16,
    parameter int WRITE_RESP = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [TAG_W-1:0]  cmd_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_rd,
    output logic              resp_error,
    output logic              reg_enable,
    output logic              reg_rqvalid,
    output logic              reg_wren,
    output logic [DATA_W-1:0] reg_wrdata,
    input  logic              reg_rdvalid,
    input  logic [DATA_W-1:0] reg_rddata,
    output logic              spurious_err
);

    if (TIMEOUT < 3 || TIMEOUT > 255) begin : g_bad_timeout
        $error("myreg_requester: TIMEOUT must be within 3..255");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t     state;
    logic       warm;
    logic [7:0] count;

    // The responder needs a cycle of reg_enable before it may see a command.
    assign cmd_ready = (state == IDLE) && warm;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            warm         <= 1'b0;
            count        <= 8'd0;
            reg_enable   <= 1'b0;
            reg_rqvalid  <= 1'b0;
            reg_wren     <= 1'b0;
            reg_wrdata   <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_rd      <= '0;
            resp_error   <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            reg_enable <= 1'b1;
            warm       <= reg_enable;

            // Any read-valid we are not waiting for, including late ones after a timeout.
            if (reg_rdvalid && state != READ_WAIT) begin
                spurious_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        resp_rd <= cmd_rd;
                        if (cmd_write) begin
                            reg_wren   <= 1'b1;
                            reg_wrdata <= cmd_wdata;
                            state      <= WRITE;
                        end else begin
                            reg_rqvalid <= 1'b1;
                            count       <= 8'd0;
                            state       <= READ_WAIT;
                        end
                    end
                end
                WRITE: begin
                    reg_wren <= 1'b0;
                    if (WRITE_RESP != 0) begin
                        resp_data  <= '0;
                        resp_error <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
                READ_WAIT: begin
                    reg_rqvalid <= 1'b0;
                    if (reg_rdvalid) begin
                        resp_data  <= reg_rddata;
                        resp_error <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (count == LAST_COUNT) begin
                        resp_data  <= '0;
                        resp_error <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_myreg_requester.sv
// tb/tb_myreg_requester.sv - scoreboard bench for myreg_requester with a one-cycle-latency register responder
module tb_myreg_requester;
    localparam int DW = 64;
    localparam int TW = 5;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [TW-1:0] cmd_rd = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_data;
    logic [TW-1:0] resp_rd;
    logic          resp_error;
    logic          reg_enable;
    logic          reg_rqvalid;
    logic          reg_wren;
    logic [DW-1:0] reg_wrdata;
    logic          reg_rdvalid;
    logic [DW-1:0] reg_rddata;
    logic          spurious_err;

    always #5 clock = ~clock;

    myreg_requester #(.DATA_W(DW), .TAG_W(TW), .TIMEOUT(TO), .WRITE_RESP(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_wdata(cmd_wdata), .cmd_rd(cmd_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_error(resp_error),
        .reg_enable(reg_enable), .reg_rqvalid(reg_rqvalid), .reg_wren(reg_wren),
        .reg_wrdata(reg_wrdata), .reg_rdvalid(reg_rdvalid), .reg_rddata(reg_rddata),
        .spurious_err(spurious_err)
    );

    // Responder model: stores writes, answers a read request one cycle later.
    logic          responder_on = 1'b1;
    logic          inj_rdv = 1'b0;
    logic          rsp_rdv = 1'b0;
    logic [DW-1:0] mem = '0;
    logic [DW-1:0] rsp_rddata = '0;
    assign reg_rdvalid = rsp_rdv | inj_rdv;
    assign reg_rddata  = rsp_rddata;

    always @(posedge clock) begin
        if (reg_wren) mem <= reg_wrdata;
        rsp_rdv    <= reg_rqvalid && responder_on;
        rsp_rddata <= mem;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] rd;
        logic          err;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    exp_t          got_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            nc = 0;
    int            acc_nc = -100;
    int            hs_nc = -100;
    int            wren_len = 0;
    int            rq_len = 0;
    logic          rv_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [TW-1:0] prev_rd = '0;
    logic          prev_err = 1'b0;
    logic [DW-1:0] exp_wdata = '0;
    logic [DW-1:0] model = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        nc++;
        if (reset_n) begin
            if (cmd_valid && cmd_ready) acc_nc = nc;
            if (resp_valid) begin
                check("busy_cmd_ready", 64'(cmd_ready), 64'(0));
                if (!rv_prev) begin
                    check("resp_expected", 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) check("resp_latency", 64'(nc - acc_nc - 1), 64'(sb[0].lat));
                end else begin
                    check("hold_data", resp_data, prev_data);
                    check("hold_rd", 64'(resp_rd), 64'(prev_rd));
                    check("hold_err", 64'(resp_error), 64'(prev_err));
                end
                if (resp_ready) begin
                    hs_nc = nc;
                    if (sb.size() != 0) begin
                        got_e = sb.pop_front();
                        check("resp_data", resp_data, got_e.data);
                        check("resp_rd", 64'(resp_rd), 64'(got_e.rd));
                        check("resp_error", 64'(resp_error), 64'(got_e.err));
                    end
                end
            end
            if (reg_wren) begin
                wren_len++;
                check("wrdata", reg_wrdata, exp_wdata);
            end else if (wren_len != 0) begin
                check("wren_width", 64'(wren_len), 64'(1));
                wren_len = 0;
            end
            if (reg_rqvalid) begin
                rq_len++;
            end else if (rq_len != 0) begin
                check("rqvalid_width", 64'(rq_len), 64'(1));
                rq_len = 0;
            end
        end else begin
            wren_len = 0;
            rq_len   = 0;
        end
        rv_prev   = resp_valid;
        prev_data = resp_data;
        prev_rd   = resp_rd;
        prev_err  = resp_error;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [TW-1:0] rd, input logic e, input int lat);
        exp_t x;
        x.data = d; x.rd = rd; x.err = e; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic send(input logic wr, input logic [DW-1:0] d, input logic [TW-1:0] rd,
                        input int lat, input logic [DW-1:0] ed, input logic ee);
        logic ok = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_wdata = d; cmd_rd = rd;
        if (wr) begin
            exp_wdata = d;
            model     = d;
        end
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clock);
            if (cmd_ready) ok = 1'b1;
        end
        check("cmd_accept", 64'(ok), 64'(1));
        if (ok) push_exp(ed, rd, ee, lat);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        check("drain", 64'(sb.size()), 64'(0));
        sb.delete();
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"}, 64'(reg_enable), 64'(0));
        check({tag, "_rqvalid"}, 64'(reg_rqvalid), 64'(0));
        check({tag, "_wren"}, 64'(reg_wren), 64'(0));
        check({tag, "_wrdata"}, reg_wrdata, 64'(0));
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        check({tag, "_resp_data"}, resp_data, 64'(0));
        check({tag, "_resp_rd"}, 64'(resp_rd), 64'(0));
        check({tag, "_resp_error"}, 64'(resp_error), 64'(0));
        check({tag, "_spurious"}, 64'(spurious_err), 64'(0));
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
    endtask

    task automatic warmup_checks(input string tag);
        @(negedge clock);
        check({tag, "_enable0"}, 64'(reg_enable), 64'(0));
        check({tag, "_ready0"}, 64'(cmd_ready), 64'(0));
        @(negedge clock);
        check({tag, "_enable1"}, 64'(reg_enable), 64'(1));
        check({tag, "_ready1"}, 64'(cmd_ready), 64'(0));
        @(negedge clock);
        check({tag, "_ready2"}, 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        logic [DW-1:0] d;
        step();
        step();
        check_all_zero("reset");

        // Command already pending when reset is released: accepted only at the 3rd edge.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 64'hDEADBEEF_CAFEF00D; cmd_rd = 5'd3;
        exp_wdata = 64'hDEADBEEF_CAFEF00D;
        model     = 64'hDEADBEEF_CAFEF00D;
        push_exp(64'd0, 5'd3, 1'b0, 1);
        reset_n = 1'b1;
        warmup_checks("warm");
        step();
        cmd_valid = 1'b0;
        wait_done();

        // Read back under backpressure, next command queued behind the response.
        resp_ready = 1'b0;
        send(1'b0, 64'd0, 5'd7, 2, model, 1'b0);
        for (int i = 0; i < 50 && !resp_valid; i++) @(negedge clock);
        check("bp_resp_seen", 64'(resp_valid), 64'(1));
        repeat (4) @(negedge clock);
        step();
        resp_ready   = 1'b1;
        responder_on = 1'b0;
        send(1'b0, 64'd0, 5'd9, TO, 64'd0, 1'b1);
        check("accept_after_hs", 64'(acc_nc - hs_nc), 64'(1));
        wait_done();
        check("timeout_no_spurious", 64'(spurious_err), 64'(0));
        responder_on = 1'b1;

        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom};
            send(1'b1, d, 5'(i), 1, 64'd0, 1'b0);
            wait_done();
            send(1'b0, 64'd0, 5'(i + 20), 2, model, 1'b0);
            wait_done();
        end

        // Reset one cycle into a read: everything drops at once, nothing comes back.
        send(1'b0, 64'd0, 5'd12, 2, model, 1'b0);
        step();
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        sb.delete();
        step();
        step();
        reset_n = 1'b1;
        warmup_checks("rewarm");
        repeat (6) step();
        check("abort_no_resp", 64'(resp_valid), 64'(0));

        inj_rdv = 1'b1;
        step();
        inj_rdv = 1'b0;
        step();
        check("spurious_set", 64'(spurious_err), 64'(1));
        check("spurious_no_resp", 64'(resp_valid), 64'(0));
        repeat (3) step();
        check("spurious_sticky", 64'(spurious_err), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
